// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared types for the eeprom controller
// Contents: command opcode enum, controller state enum, small helper.
package eeprom_pkg;

    typedef enum logic [1:0] {
        OP_READ      = 2'd0,
        OP_PROG      = 2'd1,
        OP_ERASE     = 2'd2,
        OP_ERASE_ALL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_PROG      = 3'd2,
        ST_ERASE     = 3'd3,
        ST_ERASE_ALL = 3'd4,
        ST_FINISH    = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eeprom_array.sv
// rtl/eeprom_array.sv - non-volatile DEPTH x DATA_W word store
// Ports: clk; we/waddr/wdata synchronous write port;
//        raddr/rdata combinational read port.
// Contents start all-ones (erased) and are never touched by reset.
module eeprom_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '1};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/eeprom_ctrl.sv
// rtl/eeprom_ctrl.sv - command-driven EEPROM/flash controller
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_addr/
//        cmd_wdata/wp command handshake; rd_valid/rd_data read result;
//        done/err completion pulse; busy = ~cmd_ready.
// Programming only clears bits; erase sets a word (or all words) to ones.
module eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int PROG_CYCLES  = 4,
    parameter int ERASE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              wp,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              busy
);
    localparam int CNT_W = $clog2(max_int(PROG_CYCLES, ERASE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ea_cnt_q, ea_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_pend_q, err_pend_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    eeprom_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        // Reset on the commit edge drops the pending write.
        .we    (mem_we && !rst),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ea_cnt_d   = ea_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_pend_d = err_pend_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = '1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    err_pend_d = 1'b0;
                    if (op_e'(cmd_op) == OP_READ) begin
                        state_d = ST_READ;
                    end else if (wp) begin
                        err_pend_d = 1'b1;
                        state_d    = ST_FINISH;
                    end else begin
                        case (op_e'(cmd_op))
                            OP_PROG: begin
                                cnt_d   = CNT_W'(PROG_CYCLES);
                                state_d = ST_PROG;
                            end
                            OP_ERASE: begin
                                cnt_d   = CNT_W'(ERASE_CYCLES);
                                state_d = ST_ERASE;
                            end
                            default: begin
                                ea_cnt_d = '0;
                                state_d  = ST_ERASE_ALL;
                            end
                        endcase
                    end
                end
            end
            ST_READ: begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_rdata;
                state_d    = ST_IDLE;
            end
            ST_PROG: begin
                if (cnt_q == CNT_ONE) begin
                    mem_we     = 1'b1;
                    mem_wdata  = mem_rdata & wdata_q;
                    // A 1 requested over a programmed 0 cannot be honoured.
                    err_pend_d = |(wdata_q & ~mem_rdata);
                    cnt_d      = '0;
                    state_d    = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ERASE: begin
                if (cnt_q == CNT_ONE) begin
                    mem_we  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ERASE_ALL: begin
                mem_we    = 1'b1;
                mem_waddr = ea_cnt_q;
                ea_cnt_d  = ea_cnt_q + ADDR_W'(1);
                if (&ea_cnt_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                err_d   = err_pend_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ea_cnt_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_pend_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ea_cnt_q    <= ea_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_pend_q  <= err_pend_d;
            cmd_ready_q <= cmd_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb/tb_eeprom_ctrl.sv - directed self-checking bench for eeprom_ctrl
module tb_eeprom_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        wp;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        done;
    logic        err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    eeprom_ctrl #(.DATA_W(16), .ADDR_W(4), .PROG_CYCLES(4), .ERASE_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .wp        (wp),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge. Latencies are counted
    // in edges after the acceptance edge; -1 means the event never occurred.
    task automatic issue(input logic [1:0] op, input logic [3:0] addr,
                         input logic [15:0] wd, input logic wpv,
                         output int lat_done, output int lat_rd,
                         output logic e, output logic [15:0] rd);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        wp        = wpv;
        cmd_valid = 1'b1;
        for (int k = 0; k < 100 && !cmd_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wp        = 1'b0;
        lat_done  = -1;
        lat_rd    = -1;
        e         = 1'b0;
        rd        = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (rd_valid && lat_rd < 0) begin
                lat_rd = n;
                rd     = rd_data;
            end
            if (done && lat_done < 0) begin
                lat_done = n;
                e        = err;
            end
            if (cmd_ready) break;
        end
        if (!cmd_ready) check("op_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        int ld, lr;
        logic e;
        logic [15:0] rd;
        issue(2'd0, addr, 16'h0, 1'b0, ld, lr, e, rd);
        check({tag, "_lat"}, 32'(lr), 32'd1);
        check({tag, "_data"}, 32'(rd), 32'(exp));
        check({tag, "_nodone"}, 32'(ld), 32'hFFFF_FFFF);
    endtask

    task automatic do_mod(input string tag, input logic [1:0] op, input logic [3:0] addr,
                          input logic [15:0] wd, input logic wpv,
                          input int exp_lat, input logic exp_err);
        int ld, lr;
        logic e;
        logic [15:0] rd;
        issue(op, addr, wd, wpv, ld, lr, e, rd);
        check({tag, "_lat"}, 32'(ld), 32'(exp_lat));
        check({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    initial begin
        int ld, lr, nd;
        logic [15:0] rdv;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
        cmd_wdata = '0; wp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int a = 0; a < 16; a++) begin
            do_read($sformatf("init_rd%0d", a), 4'(a), 16'hFFFF);
        end

        do_mod("prog2", 2'd1, 4'd2, 16'h00AA, 1'b0, 5, 1'b0);
        do_read("rd2_aa", 4'd2, 16'h00AA);
        do_mod("prog2_bad", 2'd1, 4'd2, 16'h0055, 1'b0, 5, 1'b1);
        do_read("rd2_00", 4'd2, 16'h0000);
        do_mod("erase2", 2'd2, 4'd2, 16'h0000, 1'b0, 9, 1'b0);
        do_read("rd2_ff", 4'd2, 16'hFFFF);

        do_mod("wp_prog4", 2'd1, 4'd4, 16'h00BB, 1'b1, 1, 1'b1);
        do_read("rd4_wp", 4'd4, 16'hFFFF);

        do_mod("prog8", 2'd1, 4'd8, 16'h00CC, 1'b0, 5, 1'b0);
        do_mod("prog15", 2'd1, 4'd15, 16'h00DD, 1'b0, 5, 1'b0);
        do_read("rd8_cc", 4'd8, 16'h00CC);
        do_mod("erase_all", 2'd3, 4'd0, 16'h0000, 1'b0, 17, 1'b0);
        do_read("rd8_ea", 4'd8, 16'hFFFF);
        do_read("rd15_ea", 4'd15, 16'hFFFF);

        // Held cmd_valid: PROG accepted, the following READ waits for ready.
        cmd_op = 2'd1; cmd_addr = 4'd3; cmd_wdata = 16'h00F0; wp = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 2'd0;
        ld = -1; lr = -1; rdv = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 2) check("hold_busy", 32'(busy), 32'd1);
            if (done && ld < 0) ld = n;
            if (rd_valid && lr < 0) begin
                lr  = n;
                rdv = rd_data;
            end
            if (lr >= 0) break;
        end
        cmd_valid = 1'b0;
        check("hold_done_lat", 32'(ld), 32'd5);
        check("hold_rd_lat", 32'(lr), 32'd7);
        check("hold_rd_data", 32'(rdv), 32'h00F0);
        @(posedge clk); #1;

        // Reset while a PROG is in flight drops the commit.
        cmd_op = 2'd1; cmd_addr = 4'd1; cmd_wdata = 16'h0000; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_ready", 32'(cmd_ready), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        nd = 0;
        for (int n = 0; n < 8; n++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        check("rstmid_nodone", 32'(nd), 32'd0);
        check("rstmid_rd_data", 32'(rd_data), 32'd0);
        do_read("rd1_rst", 4'd1, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
